// File: rtl/range_arbiter_pkg.sv
// Shared types and default widths for the two-requester range-finder arbiter.
package range_arb_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int RF_W_DEF    = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_CAPTURE,
        S_RESULT
    } state_e;

    typedef logic req_idx_t;

endpackage

// File: rtl/range_arbiter_rr.sv
// Two-way round-robin grant: a lone request wins, a tie goes to prio_i.
module rr_arbiter2
    import range_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_idx_t   prio_i,
    output logic       any_o,
    output req_idx_t   gnt_o
);

    always_comb begin
        any_o = |req_i;
        gnt_o = prio_i;
        if (req_i == 2'b01) begin
            gnt_o = 1'b0;
        end else if (req_i == 2'b10) begin
            gnt_o = 1'b1;
        end
    end

endmodule

// File: rtl/range_arbiter.sv
// Time-shares one range finder between two burst requesters, round-robin.
// Define RANGE_ARB_TIMEOUT_EN to end a stalled burst after TIMEOUT idle beats.
module range_arbiter
    import range_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RF_W   = RF_W_DEF
`ifdef RANGE_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [2*DATA_W-1:0] req_data,
    input  logic [1:0]        req_last,
    output logic [1:0]        req_ready,
    output logic              res_valid,
    output logic              res_id,
    output logic [RF_W-1:0]   res_range,
    output logic              res_error,
    input  logic              res_ready,
    output logic              rf_go,
    output logic              rf_finish,
    output logic [RF_W-1:0]   rf_data,
    input  logic [RF_W-1:0]   rf_range,
    input  logic              rf_error
);

    state_e            state_q;
    req_idx_t          g_q;
    req_idx_t          prio_q;
    req_idx_t          res_id_q;
    req_idx_t          gnt;
    logic              any_req;
    logic              first_q;
    logic              err_q;
    logic              res_error_q;
    logic [RF_W-1:0]   res_range_q;
    logic [DATA_W-1:0] sample;
    logic              stream;
    logic              beat;
    logic              last_beat;
    logic              tmo_fire;
    logic              tmo_fin;

    rr_arbiter2 u_rr (
        .req_i  (req_valid),
        .prio_i (prio_q),
        .any_o  (any_req),
        .gnt_o  (gnt)
    );

`ifdef RANGE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   idle_q;
    logic [RF_W-1:0] last_q;
    assign tmo_fire = stream && (idle_q == CW'(TIMEOUT));
`else
    assign tmo_fire = 1'b0;
`endif

    assign sample    = g_q ? req_data[2*DATA_W-1:DATA_W]
                           : req_data[DATA_W-1:0];
    assign stream    = (state_q == S_STREAM);
    assign beat      = stream && !tmo_fire && req_valid[g_q];
    assign last_beat = beat && req_last[g_q];
    assign tmo_fin   = tmo_fire && !first_q;
    assign req_ready = (stream && !tmo_fire) ? (g_q ? 2'b10 : 2'b01)
                                              : 2'b00;
    assign rf_go     = beat && first_q;
    assign rf_finish = last_beat || tmo_fin;
    assign res_valid = (state_q == S_RESULT);
    assign res_id    = res_id_q;
    assign res_range = res_range_q;
    assign res_error = res_error_q;

    // A timeout finish replays the last sample so the range is unchanged.
    always_comb begin
        rf_data = '0;
        if (beat) begin
            rf_data = RF_W'(sample);
        end
`ifdef RANGE_ARB_TIMEOUT_EN
        else if (tmo_fin) begin
            rf_data = last_q;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            g_q         <= 1'b0;
            prio_q      <= 1'b0;
            res_id_q    <= 1'b0;
            first_q     <= 1'b0;
            err_q       <= 1'b0;
            res_error_q <= 1'b0;
            res_range_q <= '0;
`ifdef RANGE_ARB_TIMEOUT_EN
            idle_q      <= '0;
            last_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        g_q     <= gnt;
                        first_q <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= S_STREAM;
`ifdef RANGE_ARB_TIMEOUT_EN
                        idle_q  <= '0;
`endif
                    end
                end
                S_STREAM: begin
                    if (rf_error) begin
                        err_q <= 1'b1;
                    end
                    if (beat) begin
                        first_q <= 1'b0;
                    end
                    if (last_beat) begin
                        state_q <= S_CAPTURE;
                    end
`ifdef RANGE_ARB_TIMEOUT_EN
                    if (beat) begin
                        idle_q <= '0;
                        last_q <= RF_W'(sample);
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                    if (tmo_fire) begin
                        idle_q <= '0;
                        if (first_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_CAPTURE;
                        end
                    end
`endif
                end
                S_CAPTURE: begin
                    res_range_q <= rf_range;
                    res_error_q <= err_q | rf_error;
                    res_id_q    <= g_q;
                    state_q     <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        prio_q  <= ~g_q;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_arbiter.sv
// Directed bench for range_arbiter with a min/max range-finder model.
module tb_range_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        res_valid;
    logic        res_id;
    logic [15:0] res_range;
    logic        res_error;
    logic        res_ready;
    logic        rf_go;
    logic        rf_finish;
    logic [15:0] rf_data;
    logic [15:0] rf_range;
    logic        rf_error;

    int n_chk  = 0;
    int n_fail = 0;

    range_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_range (res_range),
        .res_error (res_error),
        .res_ready (res_ready),
        .rf_go     (rf_go),
        .rf_finish (rf_finish),
        .rf_data   (rf_data),
        .rf_range  (rf_range),
        .rf_error  (rf_error)
    );

    always #5 clock = ~clock;

    // Finder model: range = max - min of the session, valid after finish.
    logic [15:0] mn, mx, lo, hi;
    always @(posedge clock) begin
        if (reset) begin
            rf_range <= '0;
            mn       <= '0;
            mx       <= '0;
        end else begin
            lo = mn;
            hi = mx;
            if (rf_go) begin
                lo = rf_data;
                hi = rf_data;
            end else if ((|(req_valid & req_ready)) || rf_finish) begin
                if (rf_data < lo) lo = rf_data;
                if (rf_data > hi) hi = rf_data;
            end
            mn <= lo;
            mx <= hi;
            if (rf_finish) rf_range <= hi - lo;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [1:0] l);
        req_valid = v;
        req_data  = {d1, d0};
        req_last  = l;
    endtask

    task automatic do_beat(input string tag, input int id,
                           input logic [7:0] d, input logic last,
                           input logic go);
        logic [1:0] rdy;
        rdy = (id == 1) ? 2'b10 : 2'b01;
        @(negedge clock);
        check({tag, "_rdy"}, 32'(req_ready), 32'(rdy));
        check({tag, "_go"}, 32'(rf_go), 32'(go));
        check({tag, "_fin"}, 32'(rf_finish), 32'(last));
        check({tag, "_data"}, 32'(rf_data), 32'(d));
        tick();
    endtask

    task automatic result(input string tag, input int id,
                          input logic [15:0] rng, input logic err);
        @(negedge clock);
        check({tag, "_cap"}, 32'(res_valid), 0);
        tick();
        @(negedge clock);
        check({tag, "_vld"}, 32'(res_valid), 1);
        check({tag, "_id"}, 32'(res_id), 32'(id));
        check({tag, "_rng"}, 32'(res_range), 32'(rng));
        check({tag, "_err"}, 32'(res_error), 32'(err));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rdy"}, 32'(req_ready), 0);
        check({tag, "_go"}, 32'(rf_go), 0);
        check({tag, "_fin"}, 32'(rf_finish), 0);
        check({tag, "_data"}, 32'(rf_data), 0);
        check({tag, "_vld"}, 32'(res_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int fin_cnt;
        reset     = 1'b1;
        res_ready = 1'b0;
        rf_error  = 1'b0;
        set_req(2'b00, 8'd0, 8'd0, 2'b00);
        repeat (2) tick();
        @(negedge clock);
        check_quiet("rst");
        check("rst_id", 32'(res_id), 0);
        check("rst_rng", 32'(res_range), 0);
        check("rst_err", 32'(res_error), 0);
        reset = 1'b0;
        tick();

        // Three-beat burst on requester 0
        set_req(2'b01, 8'd5, 8'd0, 2'b00);
        @(negedge clock);
        check("t1_idle_rdy", 32'(req_ready), 0);
        tick();
        do_beat("t1b0", 0, 8'd5, 1'b0, 1'b1);
        set_req(2'b01, 8'd200, 8'd0, 2'b00);
        do_beat("t1b1", 0, 8'd200, 1'b0, 1'b0);
        set_req(2'b01, 8'd17, 8'd0, 2'b01);
        do_beat("t1b2", 0, 8'd17, 1'b1, 1'b0);
        set_req(2'b00, 8'd0, 8'd0, 2'b00);
        result("t1", 0, 16'd195, 1'b0);

        // Both valid from reset: strict alternation 0,1,0
        reset = 1'b1;
        set_req(2'b11, 8'd1, 8'd2, 2'b11);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        do_beat("t2a", 0, 8'd1, 1'b1, 1'b1);
        result("t2a", 0, 16'd0, 1'b0);
        tick();
        do_beat("t2b", 1, 8'd2, 1'b1, 1'b1);
        result("t2b", 1, 16'd0, 1'b0);
        tick();
        do_beat("t2c", 0, 8'd1, 1'b1, 1'b1);
        set_req(2'b00, 8'd0, 8'd0, 2'b00);
        result("t2c", 0, 16'd0, 1'b0);

        // Single-beat burst
        set_req(2'b01, 8'd42, 8'd0, 2'b01);
        tick();
        do_beat("t3", 0, 8'd42, 1'b1, 1'b1);
        set_req(2'b00, 8'd0, 8'd0, 2'b00);
        result("t3", 0, 16'd0, 1'b0);

        // One-cycle finder error mid-burst, then a clean burst
        set_req(2'b10, 8'd0, 8'd9, 2'b00);
        tick();
        do_beat("t4b0", 1, 8'd9, 1'b0, 1'b1);
        set_req(2'b10, 8'd0, 8'd50, 2'b00);
        rf_error = 1'b1;
        do_beat("t4b1", 1, 8'd50, 1'b0, 1'b0);
        rf_error = 1'b0;
        set_req(2'b10, 8'd0, 8'd20, 2'b10);
        do_beat("t4b2", 1, 8'd20, 1'b1, 1'b0);
        set_req(2'b00, 8'd0, 8'd0, 2'b00);
        result("t4", 1, 16'd41, 1'b1);
        set_req(2'b01, 8'd7, 8'd0, 2'b00);
        tick();
        do_beat("t4n0", 0, 8'd7, 1'b0, 1'b1);
        set_req(2'b01, 8'd12, 8'd0, 2'b01);
        do_beat("t4n1", 0, 8'd12, 1'b1, 1'b0);
        set_req(2'b00, 8'd0, 8'd0, 2'b00);
        result("t4n", 0, 16'd5, 1'b0);

        // Reset mid-burst; priority returns to requester 0
        set_req(2'b10, 8'd0, 8'd3, 2'b00);
        tick();
        do_beat("t5b0", 1, 8'd3, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        @(negedge clock);
        check_quiet("t5rst");
        check("t5rst_rng", 32'(res_range), 0);
        reset = 1'b0;
        set_req(2'b00, 8'd0, 8'd0, 2'b00);
        repeat (3) begin
            @(negedge clock);
            check("t5_novld", 32'(res_valid), 0);
        end
        tick();
        set_req(2'b11, 8'd4, 8'd6, 2'b11);
        tick();
        do_beat("t5n", 0, 8'd4, 1'b1, 1'b1);
        set_req(2'b00, 8'd0, 8'd0, 2'b00);
        result("t5", 0, 16'd0, 1'b0);

`ifdef RANGE_ARB_TIMEOUT_EN
        // Stalled burst ends with a replayed finish and an error
        set_req(2'b01, 8'd10, 8'd0, 2'b00);
        tick();
        do_beat("t6b0", 0, 8'd10, 1'b0, 1'b1);
        set_req(2'b01, 8'd30, 8'd0, 2'b00);
        do_beat("t6b1", 0, 8'd30, 1'b0, 1'b0);
        set_req(2'b00, 8'd0, 8'd0, 2'b00);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (rf_finish) begin
                lat = i;
                break;
            end
        end
        check("t6_lat", 32'(lat), 16);
        check("t6_data", 32'(rf_data), 30);
        tick();
        result("t6", 0, 16'd20, 1'b1);
`else
        // Without the timeout a stalled burst simply waits
        set_req(2'b01, 8'd10, 8'd0, 2'b00);
        tick();
        do_beat("t6b0", 0, 8'd10, 1'b0, 1'b1);
        set_req(2'b00, 8'd0, 8'd0, 2'b00);
        fin_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rf_finish) fin_cnt++;
        end
        check("t6_nofin", 32'(fin_cnt), 0);
        check("t6_wait", 32'(req_ready), 1);
        tick();
        set_req(2'b01, 8'd30, 8'd0, 2'b01);
        do_beat("t6b1", 0, 8'd30, 1'b1, 1'b0);
        set_req(2'b00, 8'd0, 8'd0, 2'b00);
        result("t6", 0, 16'd20, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
